// File: rtl/if_pc_gen.sv
// IF-stage next-PC generator and single-outstanding fetch sequencer feeding if_mini_dec and ID.
// Optional build macro: IF_BTFN_PRED_EN (backward-taken/forward-not-taken branch prediction).
module if_pc_gen #(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ifu_req_valid_o,
    input  logic            ifu_req_ready_i,
    output logic [XLEN-1:0] ifu_req_pc_o,
    input  logic            ifu_rsp_valid_i,
    input  logic [31:0]     ifu_rsp_instr_i,
    output logic [31:0]     mini_instr_o,
    input  logic            mini_jal_i,
    input  logic            mini_jalr_i,
    input  logic            mini_branch_i,
    input  logic [XLEN-1:0] mini_imm_i,
    input  logic [XLEN-1:0] mini_rs1_rdata_i,
    input  logic            jalr_rs1_busy_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [31:0]     if_instr_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic            if_pred_taken_o,
    input  logic            ex_redirect_i,
    input  logic [XLEN-1:0] ex_redirect_pc_i
);

    localparam int unsigned ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h0000_0013);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_OUT,
        S_JWAIT,
        S_DRAIN
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [ILEN-1:0] instr_q;
    logic            if_valid_q;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] jalr_tgt;
    logic [XLEN-1:0] next_pc;
    logic            br_taken;
    logic            pred_taken;
    logic            jalr_stall;

    // Next-PC prediction from the decoded fields of the held instruction.
    always_comb begin
        pc_plus4   = pc_q + XLEN'(4);
        jalr_tgt   = (mini_rs1_rdata_i + mini_imm_i) & ~XLEN'(1);
`ifdef IF_BTFN_PRED_EN
        br_taken   = mini_branch_i & mini_imm_i[XLEN-1];
`else
        br_taken   = mini_branch_i & 1'b0;
`endif
        pred_taken = mini_jal_i | mini_jalr_i | br_taken;
        jalr_stall = mini_jalr_i & jalr_rs1_busy_i;
        next_pc    = pc_plus4;
        if (mini_jal_i) begin
            next_pc = pc_q + mini_imm_i;
        end else if (mini_jalr_i) begin
            next_pc = jalr_tgt;
        end else if (br_taken) begin
            next_pc = pc_q + mini_imm_i;
        end
    end

    // Sequencer: redirect wins over every state; a response owed to a flushed request is drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            if_valid_q <= 1'b0;
        end else if (ex_redirect_i) begin
            pc_q       <= ex_redirect_pc_i;
            if_valid_q <= 1'b0;
            if (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !ifu_rsp_valid_i) begin
                state_q <= S_DRAIN;
            end else begin
                state_q <= S_REQ;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (ifu_req_ready_i) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ifu_rsp_valid_i) begin
                        instr_q    <= ifu_rsp_instr_i;
                        if_valid_q <= 1'b1;
                        state_q    <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (if_ready_i) begin
                        if_valid_q <= 1'b0;
                        if (jalr_stall) begin
                            state_q <= S_JWAIT;
                        end else begin
                            pc_q    <= next_pc;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_JWAIT: begin
                    if (!jalr_rs1_busy_i) begin
                        pc_q    <= jalr_tgt;
                        state_q <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (ifu_rsp_valid_i) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    // The decoder only sees the instruction once it is held, so the taken flag follows it directly.
    assign ifu_req_valid_o = rst_n & (state_q == S_REQ) & ~ex_redirect_i;
    assign ifu_req_pc_o    = pc_q;
    assign mini_instr_o    = instr_q;
    assign if_instr_o      = instr_q;
    assign if_pc_o         = pc_q;
    assign if_valid_o      = if_valid_q;
    assign if_pred_taken_o = (state_q == S_OUT) & pred_taken;

endmodule

// File: tb/tb_if_pc_gen.sv
// Directed bench for if_pc_gen: table of fetch/predict vectors plus hand-written redirect/jalr sequences.
module tb_if_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid_o;
    logic        ifu_req_ready_i;
    logic [31:0] ifu_req_pc_o;
    logic        ifu_rsp_valid_i;
    logic [31:0] ifu_rsp_instr_i;
    logic [31:0] mini_instr_o;
    logic        mini_jal_i;
    logic        mini_jalr_i;
    logic        mini_branch_i;
    logic [31:0] mini_imm_i;
    logic [31:0] mini_rs1_rdata_i;
    logic        jalr_rs1_busy_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        if_pred_taken_o;
    logic        ex_redirect_i;
    logic [31:0] ex_redirect_pc_i;

    always #5 clk = ~clk;

    if_pc_gen dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ifu_req_valid_o  (ifu_req_valid_o),
        .ifu_req_ready_i  (ifu_req_ready_i),
        .ifu_req_pc_o     (ifu_req_pc_o),
        .ifu_rsp_valid_i  (ifu_rsp_valid_i),
        .ifu_rsp_instr_i  (ifu_rsp_instr_i),
        .mini_instr_o     (mini_instr_o),
        .mini_jal_i       (mini_jal_i),
        .mini_jalr_i      (mini_jalr_i),
        .mini_branch_i    (mini_branch_i),
        .mini_imm_i       (mini_imm_i),
        .mini_rs1_rdata_i (mini_rs1_rdata_i),
        .jalr_rs1_busy_i  (jalr_rs1_busy_i),
        .if_valid_o       (if_valid_o),
        .if_ready_i       (if_ready_i),
        .if_instr_o       (if_instr_o),
        .if_pc_o          (if_pc_o),
        .if_pred_taken_o  (if_pred_taken_o),
        .ex_redirect_i    (ex_redirect_i),
        .ex_redirect_pc_i (ex_redirect_pc_i)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        jal;
        logic        jalr;
        logic        br;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        pred;
    } vec_t;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JAL  = 32'h0000_006F;
    localparam logic [31:0] BEQ  = 32'hFE00_0CE3;
    localparam logic [31:0] JALR = 32'h0000_8067;

`ifdef IF_BTFN_PRED_EN
    localparam logic        BTFN  = 1'b1;
    localparam logic [31:0] BR_PC = 32'h8000_0038;
`else
    localparam logic        BTFN  = 1'b0;
    localparam logic [31:0] BR_PC = 32'h8000_0044;
`endif

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, check its address, complete the handshake.
    task automatic wait_req(input string name, input logic [31:0] exp_pc, output int lat);
        lat = -1;
        ifu_req_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (ifu_req_valid_o) begin
                lat = i;
                chk({name, "_req_pc"}, ifu_req_pc_o, exp_pc);
                step();
                break;
            end
            step();
        end
        ifu_req_ready_i = 1'b0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_req_timeout actual=no_request required=request", name);
        end
    endtask

    // One full fetch: request, immediate response, present to ID, decode, accept.
    task automatic fetch(input string name, input vec_t v);
        int lat;
        wait_req(name, v.pc, lat);
        chk({name, "_req_lat"}, 32'(lat), 32'd0);
        ifu_rsp_valid_i = 1'b1;
        ifu_rsp_instr_i = v.instr;
        step();
        ifu_rsp_valid_i  = 1'b0;
        mini_jal_i       = v.jal;
        mini_jalr_i      = v.jalr;
        mini_branch_i    = v.br;
        mini_imm_i       = v.imm;
        mini_rs1_rdata_i = v.rs1;
        #1;
        chk({name, "_if_valid"}, 32'(if_valid_o), 32'd1);
        chk({name, "_if_pc"}, if_pc_o, v.pc);
        chk({name, "_if_instr"}, if_instr_o, v.instr);
        chk({name, "_mini_instr"}, mini_instr_o, v.instr);
        chk({name, "_pred"}, 32'(if_pred_taken_o), 32'(v.pred));
        if_ready_i = 1'b1;
        step();
        if_ready_i    = 1'b0;
        mini_jal_i    = 1'b0;
        mini_jalr_i   = 1'b0;
        mini_branch_i = 1'b0;
        mini_imm_i    = '0;
        mini_rs1_rdata_i = '0;
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        ifu_req_ready_i  = 1'b0;
        ifu_rsp_valid_i  = 1'b0;
        ifu_rsp_instr_i  = '0;
        mini_jal_i       = 1'b0;
        mini_jalr_i      = 1'b0;
        mini_branch_i    = 1'b0;
        mini_imm_i       = '0;
        mini_rs1_rdata_i = '0;
        jalr_rs1_busy_i  = 1'b0;
        if_ready_i       = 1'b0;
        ex_redirect_i    = 1'b0;
        ex_redirect_pc_i = '0;

        tbl[0]  = '{32'h8000_0000, NOP,  1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0};
        tbl[1]  = '{32'h8000_0004, NOP,  1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0};
        tbl[2]  = '{32'h8000_0008, JAL,  1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0,         1'b1};
        tbl[3]  = '{32'h8000_0010, JAL,  1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b1};
        tbl[4]  = '{32'h8000_0020, JAL,  1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0,         1'b1};
        tbl[5]  = '{32'h8000_0040, BEQ,  1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0,         BTFN};
        tbl[6]  = '{BR_PC,         BEQ,  1'b0, 1'b0, 1'b1, 32'h0000_000C, 32'h0,         1'b0};
        tbl[7]  = '{BR_PC + 32'd4, NOP,  1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0};
        tbl[8]  = '{BR_PC + 32'd8, JALR, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_3001, 1'b1};
        tbl[9]  = '{32'h0000_3010, NOP,  1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0};
        tbl[10] = '{32'h0000_3014, JAL,  1'b1, 1'b0, 1'b0, 32'hFFFF_D000, 32'h0,         1'b1};
        tbl[11] = '{32'h0000_0014, NOP,  1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0};

        #12;
        chk("rst_req_valid", 32'(ifu_req_valid_o), 32'd0);
        chk("rst_if_valid", 32'(if_valid_o), 32'd0);
        chk("rst_pred", 32'(if_pred_taken_o), 32'd0);
        chk("rst_instr", mini_instr_o, NOP);
        chk("rst_pc", ifu_req_pc_o, 32'h8000_0000);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            fetch($sformatf("vec%0d", i), tbl[i]);
        end

        // jalr with rs1 busy for three cycles: ID takes it, sequencer parks in JWAIT.
        wait_req("jalr", 32'h0000_0018, lat);
        chk("jalr_req_lat", 32'(lat), 32'd0);
        ifu_rsp_valid_i = 1'b1;
        ifu_rsp_instr_i = JALR;
        step();
        ifu_rsp_valid_i  = 1'b0;
        mini_jalr_i      = 1'b1;
        mini_rs1_rdata_i = 32'h0000_1003;
        mini_imm_i       = 32'h0000_0004;
        jalr_rs1_busy_i  = 1'b1;
        if_ready_i       = 1'b1;
        #1;
        chk("jalr_if_valid", 32'(if_valid_o), 32'd1);
        chk("jalr_pred", 32'(if_pred_taken_o), 32'd1);
        step();
        if_ready_i = 1'b0;
        #1;
        chk("jwait_if_valid", 32'(if_valid_o), 32'd0);
        chk("jwait_req_valid0", 32'(ifu_req_valid_o), 32'd0);
        step();
        #1;
        chk("jwait_req_valid1", 32'(ifu_req_valid_o), 32'd0);
        step();
        jalr_rs1_busy_i = 1'b0;
        #1;
        chk("jwait_req_valid2", 32'(ifu_req_valid_o), 32'd0);
        step();
        mini_jalr_i      = 1'b0;
        mini_rs1_rdata_i = '0;
        mini_imm_i       = '0;
        wait_req("jalr_tgt", 32'h0000_1006, lat);
        chk("jalr_tgt_lat", 32'(lat), 32'd0);

        // Redirect while WAIT; the late response must be dropped.
        ex_redirect_i    = 1'b1;
        ex_redirect_pc_i = 32'h0000_2000;
        step();
        ex_redirect_i   = 1'b0;
        ifu_rsp_valid_i = 1'b1;
        ifu_rsp_instr_i = 32'hDEAD_BEEF;
        step();
        ifu_rsp_valid_i = 1'b0;
        #1;
        chk("drain_if_valid", 32'(if_valid_o), 32'd0);
        chk("drain_instr_kept", mini_instr_o, JALR);
        chk("drain_req_valid", 32'(ifu_req_valid_o), 32'd1);
        chk("drain_req_pc", ifu_req_pc_o, 32'h0000_2000);

        // Redirect in REQ with ready high masks the request that cycle.
        ifu_req_ready_i  = 1'b1;
        ex_redirect_i    = 1'b1;
        ex_redirect_pc_i = 32'h0000_3000;
        #1;
        chk("req_redir_mask", 32'(ifu_req_valid_o), 32'd0);
        step();
        ex_redirect_i   = 1'b0;
        ifu_req_ready_i = 1'b0;
        wait_req("req_redir", 32'h0000_3000, lat);
        chk("req_redir_lat", 32'(lat), 32'd0);
        ifu_rsp_valid_i = 1'b1;
        ifu_rsp_instr_i = NOP;
        step();
        ifu_rsp_valid_i = 1'b0;
        #1;
        chk("hold_if_valid0", 32'(if_valid_o), 32'd1);
        step();
        #1;
        chk("hold_if_valid1", 32'(if_valid_o), 32'd1);
        chk("hold_if_pc", if_pc_o, 32'h0000_3000);

        // Redirect in OUT while ID stalls.
        ex_redirect_i    = 1'b1;
        ex_redirect_pc_i = 32'h0000_4000;
        step();
        ex_redirect_i = 1'b0;
        #1;
        chk("out_redir_if_valid", 32'(if_valid_o), 32'd0);
        chk("out_redir_req_valid", 32'(ifu_req_valid_o), 32'd1);
        chk("out_redir_req_pc", ifu_req_pc_o, 32'h0000_4000);

        // Stray response in REQ must be ignored.
        ifu_rsp_valid_i = 1'b1;
        ifu_rsp_instr_i = 32'h1234_5678;
        step();
        ifu_rsp_valid_i = 1'b0;
        #1;
        chk("stray_instr", mini_instr_o, NOP);
        chk("stray_if_valid", 32'(if_valid_o), 32'd0);
        chk("stray_req_pc", ifu_req_pc_o, 32'h0000_4000);
        fetch("post", '{32'h0000_4000, NOP, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
